// File: rtl/jt5205_seq.sv
// jt5205_seq: ADPCM sample-playback sequencer for the JT5205 core.
// Fetches packed 4-bit ADPCM bytes from a byte-wide ROM over a cs/ok
// handshake between a start and an inclusive end address, and presents
// one nibble per sample strobe (high nibble first) to the decoder.
// Optional feature: define JT5205_SEQ_LOOP_EN to add the `loop` input,
// which restarts playback from the latched start address at end of sample.
module jt5205_seq #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vclk,
    input  logic          start,
    input  logic          stop,
`ifdef JT5205_SEQ_LOOP_EN
    input  logic          loop,
`endif
    input  logic [AW-1:0] addr_start,
    input  logic [AW-1:0] addr_end,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    din,
    output logic          dec_rst,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    typedef enum logic [1:0] {IDLE, FILL, PLAY} state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [AW-1:0] end_addr;
`ifdef JT5205_SEQ_LOOP_EN
    logic [AW-1:0] first_addr;
`endif
    logic [7:0]    nxt;
    logic [7:0]    cur;
    logic          nxt_valid;
    logic          nxt_last;
    logic          cur_last;
    logic          phase;
    logic          fetch_done;

    // Player FSM, ROM fetcher and nibble output, all registered together.
    // Fetcher and consumer never touch nxt_valid in the same cycle: a
    // request is only raised while nxt_valid=0 and a byte is only consumed
    // while nxt_valid=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            end_addr   <= '0;
`ifdef JT5205_SEQ_LOOP_EN
            first_addr <= '0;
`endif
            nxt        <= '0;
            cur        <= '0;
            nxt_valid  <= 1'b0;
            nxt_last   <= 1'b0;
            cur_last   <= 1'b0;
            phase      <= 1'b0;
            fetch_done <= 1'b0;
            rom_addr   <= '0;
            rom_cs     <= 1'b0;
            din        <= '0;
            dec_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                busy      <= 1'b0;
                dec_rst   <= 1'b1;
                rom_cs    <= 1'b0;
                din       <= '0;
                nxt_valid <= 1'b0;
                cur_last  <= 1'b0;
                phase     <= 1'b0;
            end else if (start) begin
                // The first request goes out on the start edge itself.
                state      <= FILL;
                addr       <= addr_start;
                end_addr   <= addr_end;
`ifdef JT5205_SEQ_LOOP_EN
                first_addr <= addr_start;
`endif
                busy       <= 1'b1;
                dec_rst    <= 1'b0;
                nxt_valid  <= 1'b0;
                cur_last   <= 1'b0;
                phase      <= 1'b0;
                fetch_done <= 1'b0;
                rom_cs     <= 1'b1;
                rom_addr   <= addr_start;
            end else if (state != IDLE) begin
                if (rom_cs) begin
                    if (rom_ok) begin
                        nxt        <= rom_data;
                        nxt_valid  <= 1'b1;
                        nxt_last   <= (addr >= end_addr);
                        fetch_done <= (addr >= end_addr);
                        addr       <= addr + 1'b1;
                        rom_cs     <= 1'b0;
                    end
                end else if (!nxt_valid && !fetch_done) begin
                    rom_cs   <= 1'b1;
                    rom_addr <= addr;
                end

                if (state == FILL) begin
                    if (nxt_valid)
                        state <= PLAY;
                end else if (vclk) begin
                    if (phase) begin
                        din   <= cur[3:0];
                        phase <= 1'b0;
                    end else if (cur_last) begin
                        done <= 1'b1;
`ifdef JT5205_SEQ_LOOP_EN
                        if (loop) begin
                            state      <= FILL;
                            addr       <= first_addr;
                            cur_last   <= 1'b0;
                            fetch_done <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            dec_rst <= 1'b1;
                        end
`else
                        state   <= IDLE;
                        busy    <= 1'b0;
                        dec_rst <= 1'b1;
`endif
                    end else if (nxt_valid) begin
                        cur       <= nxt;
                        cur_last  <= nxt_last;
                        nxt_valid <= 1'b0;
                        din       <= nxt[7:4];
                        phase     <= 1'b1;
                    end else begin
                        underrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
